// File: rtl/jk_reg_bank_if.sv
// Handshake bundle for jk_reg_bank: control, JK inputs and state outputs.
// master drives controls; slave is the register bank.
interface jk_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic             pre;
    logic             ce;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output pre, ce, mode, j, k,
        input  q, qbar, tc, rise, fall
    );

    modport slave (
        input  pre, ce, mode, j, k,
        output q, qbar, tc, rise, fall
    );
endinterface

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK flip-flop bank, reconfigurable as up/down counter.
// Define JK_REG_BANK_EDGE_EN to compile in registered rise/fall pulses.
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRE_VAL = '1
) (
    input  logic          clk,
    input  logic          clr,
    jk_reg_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DN   = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;

    assign mode = mode_e'(bus.mode);

    // Toggle chains: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic ones;
        logic zeros;
        t_up  = '0;
        t_dn  = '0;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = ones;
            t_dn[i] = zeros;
            ones    = ones & q_q[i];
            zeros   = zeros & ~q_q[i];
        end
    end

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (bus.pre) begin
            q_d = PRE_VAL;
        end else if (bus.ce) begin
            unique case (mode)
                MODE_JK:   q_d = (bus.j & ~q_q) | (~bus.k & q_q);
                MODE_UP:   q_d = q_q ^ t_up;
                MODE_DN:   q_d = q_q ^ t_dn;
                MODE_HOLD: q_d = q_q;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign bus.q    = q_q;
    assign bus.qbar = ~q_q;
    assign bus.tc   = bus.ce & (((mode == MODE_UP) & (&q_q)) |
                                ((mode == MODE_DN) & ~(|q_q)));

`ifdef JK_REG_BANK_EDGE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // clr drops any pending pulse, but prev_q still tracks so the
    // transition caused by clr is reported on the following edge.
    always_ff @(posedge clk) begin
        prev_q <= q_q;
        if (clr) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= q_q & ~prev_q;
            fall_q <= ~q_q & prev_q;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`else
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=8).
// Edge-pulse expectations follow JK_REG_BANK_EDGE_EN.
module tb_jk_reg_bank;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    jk_reg_bank_if #(.WIDTH(8)) bus ();

    jk_reg_bank #(.WIDTH(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef JK_REG_BANK_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr      = 1'b0;
        bus.pre  = 1'b0;
        bus.ce   = 1'b0;
        bus.mode = 2'b11;
        bus.j    = 8'h00;
        bus.k    = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] er;
        idle();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        checks++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL reset_q got=%h exp=00", bus.q);
        end
        checks++;
        if (bus.qbar !== 8'hFF) begin
            errors++;
            $display("FAIL reset_qbar got=%h exp=FF", bus.qbar);
        end
        checks++;
        if (bus.rise !== 8'h00 || bus.fall !== 8'h00) begin
            errors++;
            $display("FAIL reset_edges got=%h/%h exp=00/00",
                     bus.rise, bus.fall);
        end
        checks++;
        if (bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc got=%b exp=0", bus.tc);
        end
        bus.ce   = 1'b1;
        bus.mode = 2'b10;
        #1;
        checks++;
        if (bus.tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_down got=%b exp=1", bus.tc);
        end
        er = 8'h00;
        idle();
    endtask

    task automatic test_preset();
        idle();
        bus.pre = 1'b1;
        tick();
        checks++;
        if (bus.q !== 8'hFF || bus.qbar !== 8'h00) begin
            errors++;
            $display("FAIL preset got=%h/%h exp=FF/00", bus.q, bus.qbar);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL clr_pre got=%h exp=00", bus.q);
        end
        idle();
    endtask

    task automatic test_jk();
        logic [7:0] jv [4] = '{8'hF0, 8'hFF, 8'h00, 8'hFF};
        logic [7:0] kv [4] = '{8'h00, 8'hFF, 8'h0C, 8'hFF};
        logic       cv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] ev [4] = '{8'hF0, 8'h0F, 8'h03, 8'h03};
        idle();
        bus.mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            bus.j  = jv[i];
            bus.k  = kv[i];
            bus.ce = cv[i];
            #1;
            checks++;
            if (bus.tc !== 1'b0) begin
                errors++;
                $display("FAIL jk_tc%0d got=%b exp=0", i, bus.tc);
            end
            tick();
            checks++;
            if (bus.q !== ev[i]) begin
                errors++;
                $display("FAIL jk_step%0d got=%h exp=%h", i, bus.q, ev[i]);
            end
        end
        bus.mode = 2'b11;
        bus.ce   = 1'b1;
        tick();
        checks++;
        if (bus.q !== 8'h03) begin
            errors++;
            $display("FAIL jk_mode11 got=%h exp=03", bus.q);
        end
        idle();
    endtask

    task automatic test_up_wrap();
        idle();
        bus.pre = 1'b1;
        tick();
        bus.pre  = 1'b0;
        bus.mode = 2'b01;
        bus.ce   = 1'b1;
        bus.j    = 8'hFF;
        bus.k    = 8'hFF;
        #1;
        checks++;
        if (bus.tc !== 1'b1) begin
            errors++;
            $display("FAIL up_tc_ff got=%b exp=1", bus.tc);
        end
        tick();
        checks++;
        if (bus.q !== 8'h00 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap got=%h tc=%b exp=00 tc=0", bus.q, bus.tc);
        end
        for (int n = 1; n <= 256; n++) begin
            tick();
            if (n == 100) begin
                checks++;
                if (bus.q !== 8'h64) begin
                    errors++;
                    $display("FAIL up_100 got=%h exp=64", bus.q);
                end
            end
            if (n == 255) begin
                checks++;
                if (bus.q !== 8'hFF || bus.tc !== 1'b1) begin
                    errors++;
                    $display("FAIL up_255 got=%h tc=%b exp=FF tc=1",
                             bus.q, bus.tc);
                end
            end
        end
        checks++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL up_256 got=%h exp=00", bus.q);
        end
        idle();
    endtask

    task automatic test_down_wrap();
        logic [7:0] ev [2] = '{8'hFF, 8'hFE};
        idle();
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        bus.mode = 2'b10;
        bus.ce   = 1'b1;
        #1;
        checks++;
        if (bus.tc !== 1'b1) begin
            errors++;
            $display("FAIL dn_tc_00 got=%b exp=1", bus.tc);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.q !== ev[i] || bus.tc !== 1'b0) begin
                errors++;
                $display("FAIL dn_step%0d got=%h tc=%b exp=%h tc=0",
                         i, bus.q, bus.tc, ev[i]);
            end
        end
        bus.mode = 2'b01;
        tick();
        checks++;
        if (bus.q !== 8'hFF || bus.tc !== 1'b1) begin
            errors++;
            $display("FAIL dn_to_up got=%h tc=%b exp=FF tc=1", bus.q, bus.tc);
        end
        idle();
    endtask

    task automatic test_hold_clr();
        idle();
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        bus.mode = 2'b01;
        bus.ce   = 1'b1;
        repeat (8'h37) tick();
        checks++;
        if (bus.q !== 8'h37) begin
            errors++;
            $display("FAIL cnt_37 got=%h exp=37", bus.q);
        end
        bus.mode = 2'b11;
        tick();
        tick();
        checks++;
        if (bus.q !== 8'h37 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL hold_37 got=%h tc=%b exp=37 tc=0", bus.q, bus.tc);
        end
        bus.mode = 2'b01;
        tick();
        checks++;
        if (bus.q !== 8'h38) begin
            errors++;
            $display("FAIL resume got=%h exp=38", bus.q);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL mid_clr got=%h exp=00", bus.q);
        end
        idle();
    endtask

    task automatic test_edges();
        logic [7:0] jv [5] = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h81};
        logic [7:0] kv [5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
        logic [7:0] qv [5] = '{8'h81, 8'h01, 8'h01, 8'h01, 8'h81};
        logic [7:0] rv [5] = '{8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
        logic [7:0] fv [5] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
        logic [7:0] er;
        logic [7:0] ef;
        idle();
        clr = 1'b1;
        tick();
        tick();
        clr      = 1'b0;
        bus.mode = 2'b00;
        bus.ce   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.j = jv[i];
            bus.k = kv[i];
            tick();
            er = EDGE ? rv[i] : 8'h00;
            ef = EDGE ? fv[i] : 8'h00;
            checks++;
            if (bus.q !== qv[i] || bus.rise !== er || bus.fall !== ef) begin
                errors++;
                $display("FAIL edge_step%0d got q=%h r=%h f=%h exp q=%h r=%h f=%h",
                         i, bus.q, bus.rise, bus.fall, qv[i], er, ef);
            end
        end
        // q went 01->81 on the last edge; clr swallows that rise pulse
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.ce = 1'b0;
        checks++;
        if (bus.q !== 8'h00 || bus.rise !== 8'h00 || bus.fall !== 8'h00) begin
            errors++;
            $display("FAIL edge_clr got q=%h r=%h f=%h exp q=00 r=00 f=00",
                     bus.q, bus.rise, bus.fall);
        end
        tick();
        ef = EDGE ? 8'h81 : 8'h00;
        checks++;
        if (bus.rise !== 8'h00 || bus.fall !== ef) begin
            errors++;
            $display("FAIL edge_after_clr got r=%h f=%h exp r=00 f=%h",
                     bus.rise, bus.fall, ef);
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        test_reset();
        test_preset();
        test_jk();
        test_up_wrap();
        test_down_wrap();
        test_hold_clr();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
